// File: rtl/zoom_bilinear.sv
// Four-stage bilinear interpolation kernel with valid/ready flow control.
// Optional macro ZOOM_BILINEAR_ROUND_EN selects round-half-up instead of floor.
module zoom_bilinear #(
  parameter int PW = 6,
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] dx,
  input  logic [FW-1:0] dy,
  input  logic [PW-1:0] pixel_1,
  input  logic [PW-1:0] pixel_2,
  input  logic [PW-1:0] pixel_3,
  input  logic [PW-1:0] pixel_4,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] pout
);

  localparam int MW  = PW + FW + 1;
  localparam int AAW = PW + FW + 3;
  localparam int MMW = PW + 2*FW + 2;
  localparam int AW  = PW + 2*FW + 3;

`ifdef ZOOM_BILINEAR_ROUND_EN
  localparam logic [AW-1:0] RND = AW'(1) << (2*FW - 1);
`else
  localparam logic [AW-1:0] RND = '0;
`endif

  logic en;
  logic v1, v2, v3;

  logic signed [PW:0]   d21_1, d31_1;
  logic signed [PW+1:0] d4_1;
  logic [FW-1:0]        dx_1, dy_1;
  logic [PW-1:0]        p1_1;

  logic signed [MW-1:0] m21_2, m31_2;
  logic [2*FW-1:0]      dxy_2;
  logic signed [PW+1:0] d4_2;
  logic [PW-1:0]        p1_2;

  logic signed [AAW-1:0] a_3;
  logic signed [MMW-1:0] m_3;

  logic signed [PW:0]    d21_n, d31_n;
  logic signed [PW+1:0]  d4_n;
  logic signed [MW-1:0]  m21_n, m31_n;
  logic [2*FW-1:0]       dxy_n;
  logic signed [AAW-1:0] a_n;
  logic signed [MMW-1:0] m_n;
  logic signed [AW-1:0]  acc_sum;
  logic                  unused_acc;

  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  // Operands are zero- or sign-extended to the product width so no term truncates.
  always_comb begin
    d21_n = $signed({1'b0, pixel_2}) - $signed({1'b0, pixel_1});
    d31_n = $signed({1'b0, pixel_3}) - $signed({1'b0, pixel_1});
    d4_n  = $signed({2'b00, pixel_4}) + $signed({2'b00, pixel_1})
          - $signed({2'b00, pixel_2}) - $signed({2'b00, pixel_3});

    m21_n = $signed({{FW{d21_1[PW]}}, d21_1}) * $signed({{(PW+1){1'b0}}, dx_1});
    m31_n = $signed({{FW{d31_1[PW]}}, d31_1}) * $signed({{(PW+1){1'b0}}, dy_1});
    dxy_n = {{FW{1'b0}}, dx_1} * {{FW{1'b0}}, dy_1};

    a_n = $signed({3'b000, p1_2, {FW{1'b0}}})
        + $signed({{2{m21_2[MW-1]}}, m21_2})
        + $signed({{2{m31_2[MW-1]}}, m31_2});
    m_n = $signed({{(2*FW){d4_2[PW+1]}}, d4_2}) * $signed({{(PW+2){1'b0}}, dxy_2});

    acc_sum = $signed({a_3, {FW{1'b0}}}) + $signed({m_3[MMW-1], m_3}) + $signed(RND);
  end

  assign unused_acc = ^{acc_sum[2*FW-1:0], acc_sum[AW-1:2*FW+PW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      pout      <= '0;
      d21_1     <= '0;
      d31_1     <= '0;
      d4_1      <= '0;
      dx_1      <= '0;
      dy_1      <= '0;
      p1_1      <= '0;
      m21_2     <= '0;
      m31_2     <= '0;
      dxy_2     <= '0;
      d4_2      <= '0;
      p1_2      <= '0;
      a_3       <= '0;
      m_3       <= '0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      d21_1     <= d21_n;
      d31_1     <= d31_n;
      d4_1      <= d4_n;
      dx_1      <= dx;
      dy_1      <= dy;
      p1_1      <= pixel_1;
      m21_2     <= m21_n;
      m31_2     <= m31_n;
      dxy_2     <= dxy_n;
      d4_2      <= d4_1;
      p1_2      <= p1_1;
      a_3       <= a_n;
      m_3       <= m_n;
      if (v3) pout <= acc_sum[2*FW +: PW];
    end
  end

endmodule

// File: tb/tb_zoom_bilinear.sv
// Scoreboard bench for zoom_bilinear: weighted-sum reference model, random back-pressure,
// full-rate streaming and mid-stream reset.
module tb_zoom_bilinear;
  localparam int PW = 6;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] dx, dy;
  logic [PW-1:0] pixel_1, pixel_2, pixel_3, pixel_4;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] pout;

  zoom_bilinear #(.PW(PW), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dx(dx), .dy(dy), .pixel_1(pixel_1), .pixel_2(pixel_2),
    .pixel_3(pixel_3), .pixel_4(pixel_4), .out_valid(out_valid),
    .out_ready(out_ready), .pout(pout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp;
    int acc;
    bit lat;
  } sb_t;

  sb_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  cur_exp = 0;
  bit  cur_lat = 1'b0;
  bit  bp_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Weighted form of the bilinear sum: each corner times its area weight.
  function automatic int ref_pix(int p1, int p2, int p3, int p4, int x, int y);
    int n;
    int s;
    n = 1 << FW;
    s = p1*(n-x)*(n-y) + p2*x*(n-y) + p3*(n-x)*y + p4*x*y;
`ifdef ZOOM_BILINEAR_ROUND_EN
    s = s + (1 << (2*FW-1));
`endif
    return s >> (2*FW);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send(input int a, input int b, input int c, input int d,
                      input int x, input int y, input int req, input bit lat);
    int n;
    pixel_1  = PW'(a);
    pixel_2  = PW'(b);
    pixel_3  = PW'(c);
    pixel_4  = PW'(d);
    dx       = FW'(x);
    dy       = FW'(y);
    cur_exp  = req;
    cur_lat  = lat;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", n, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat);
    int a, b, c, d, x, y;
    a = $urandom_range(0, 63);
    b = $urandom_range(0, 63);
    c = $urandom_range(0, 63);
    d = $urandom_range(0, 63);
    x = $urandom_range(0, 15);
    y = $urandom_range(0, 15);
    send(a, b, c, d, x, y, ref_pix(a, b, c, d, x, y), lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", sbq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: outputs, handshake rule, stall stability and accumulator range.
  initial begin
    bit   prev_stall;
    logic [PW-1:0] prev_pout;
    sb_t  e;
    prev_stall = 1'b0;
    prev_pout  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready_rule", int'(in_ready), int'(out_ready || !out_valid));
        if (prev_stall) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_pout", int'(pout), int'(prev_pout));
        end
        if (dut.v3) begin
          check("acc_sign", int'(dut.acc_sum[PW+2*FW+2]), 0);
          check("acc_ovf", int'(dut.acc_sum[PW+2*FW+1:PW+2*FW]), 0);
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            check("spurious_out", int'(pout), -1);
          end else begin
            e = sbq.pop_front();
            check("pout", int'(pout), e.exp);
            if (e.lat) check("latency", cyc - e.acc, 4);
          end
        end
        if (in_valid && in_ready) sbq.push_back('{cur_exp, cyc, cur_lat});
        prev_stall = out_valid && !out_ready;
        prev_pout  = pout;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    int a, b, c, d, x, y;
    rst_n = 1'b0; in_valid = 1'b0;
    pixel_1 = '0; pixel_2 = '0; pixel_3 = '0; pixel_4 = '0; dx = '0; dy = '0;
    #3;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_pout", int'(pout), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(10, 20, 30, 40, 8, 8, 25, 1'b1);
    send(7, 50, 33, 63, 0, 0, 7, 1'b1);
    send(63, 63, 63, 63, 15, 15, 63, 1'b1);
`ifdef ZOOM_BILINEAR_ROUND_EN
    send(0, 1, 0, 0, 8, 0, 1, 1'b1);
`else
    send(0, 1, 0, 0, 8, 0, 0, 1'b1);
`endif
    drain();

    for (int i = 0; i < 16; i++) send_rand(1'b1);
    drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand(1'b0);
    end
    drain();
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(10, 20, 30, 40, 8, 8, 25, 1'b1);
    for (int i = 0; i < 3; i++) send_rand(1'b1);
    check("pre_rst_valid", int'(out_valid), 1);
    check("pre_rst_pout", int'(pout), 25);
    #1;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_pout", int'(pout), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_idle", int'(out_valid), 0);
    a = 5; b = 60; c = 17; d = 42; x = 3; y = 11;
    send(a, b, c, d, x, y, ref_pix(a, b, c, d, x, y), 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
